// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequencer: one 4-bit carry-lookahead adder is reused once per
// clock, LSB nibble first, with valid/ready handshakes on both the operand and result sides.

module cl_adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is flattened from generate/propagate terms, so none of them ripples.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic               SUB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*NIBBLES-1:0] S,
  output logic               Cout,
  output logic               OVF,
  output logic               ZERO
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    s_q;
  logic [W-1:0]    s_d;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [3:0]      add_a;
  logic [3:0]      add_b;
  logic [3:0]      add_s;
  logic            add_c;

  assign add_a = a_q[{idx_q, 2'b00} +: 4];
  assign add_b = b_q[{idx_q, 2'b00} +: 4];

  cl_adder4 u_adder (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  // Full sum with the current nibble merged in; lets the last edge derive flags from the final S.
  always_comb begin
    // NOTE: default assignment first so every path drives s_d and no latch is inferred.
    s_d = s_q;
    s_d[{idx_q, 2'b00} +: 4] = add_s;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B ^ {W{SUB}};
            carry_q    <= SUB;
            idx_q      <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= add_c;
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= add_c;
            ovf_q       <= (a_q[W-1] == b_q[W-1]) && (s_d[W-1] != a_q[W-1]);
            zero_q      <= (s_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a 16-bit instance driven from a vector
// table plus handshake/reset sequences, and a 4-bit instance for the single-nibble case.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        sub1 = 1'b0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [3:0]  s1;
  logic        cout1;
  logic        ovf1;
  logic        zero1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .SUB       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .Cout      (cout),
    .OVF       (ovf),
    .ZERO      (zero)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .A         (a1),
    .B         (b1),
    .SUB       (sub1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .S         (s1),
    .Cout      (cout1),
    .OVF       (ovf1),
    .ZERO      (zero1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents operands, waits (bounded) for in_ready, and returns just after the accept edge.
  task automatic accept(input logic [15:0] va, input logic [15:0] vb, input logic vsub);
    int n;
    @(negedge clk);
    a        = va;
    b        = vb;
    sub      = vsub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    #17;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sub);
      // Scramble inputs right after acceptance; the operation in flight must not notice.
      in_valid = 1'b0;
      a   = 16'hDEAD;
      b   = 16'hBEEF;
      sub = ~sub;
      wait_result(4);
      check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
      handshake();
      check($sformatf("vec%0d_s_hold", i), 32'(s), 32'(vecs[i].exp_s));
    end

    // Backpressure: in_valid stays high with the next operands throughout RUN and DONE.
    accept(16'h1111, 16'h2222, 1'b0);
    a = 16'h0F0F;
    b = 16'h0101;
    wait_result(4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_s", 32'(s), 32'h3333);
      check("bp_flags", {29'd0, cout, ovf, zero}, 32'd0);
    end
    handshake();
    @(posedge clk);
    #1;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_result(4);
    check("bp_next_s", 32'(s), 32'h1010);
    handshake();

    // Reset in the middle of RUN, after two nibbles have been written.
    accept(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_partial_s", 32'(s), 32'h0055);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("mid_rst_no_emit", 32'(lat), 32'd0);
    accept(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_result(4);
    check("post_rst_s", 32'(s), 32'h0002);
    handshake();

    // Single-nibble instance: RUN lasts exactly one cycle.
    @(negedge clk);
    a1 = 4'h9;
    b1 = 4'h8;
    sub1 = 1'b0;
    in_valid1 = 1'b1;
    check("n1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("n1_latency", 32'(lat), 32'd1);
    check("n1_s", 32'(s1), 32'h1);
    check("n1_cout", 32'(cout1), 32'd1);
    check("n1_ovf", 32'(ovf1), 32'd1);
    check("n1_zero", 32'(zero1), 32'd0);
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    check("n1_out_valid_after_hs", 32'(out_valid1), 32'd0);
    check("n1_in_ready_after_hs", 32'(in_ready1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing one instance of the existing 4-bit carry-lookahead adder (cl_adder4), one nibble per clock, LSB nibble first.
- Operand width is 4*NIBBLES bits.
- Accepts operands over a valid/ready input handshake and returns sum and flags over a valid/ready output handshake.
- Serves as the arithmetic engine for the training designs, trading latency for a single 4-bit adder.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands A, B, SUB valid.
- in_ready  output  1  controller can accept operands.
- A  input  W  operand A.
- B  input  W  operand B.
- SUB  input  1  0 = A+B; 1 = A-B (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  W  sum/difference.
- Cout  output  1  carry out of MSB nibble; for SUB=1 this is 1 when A >= B unsigned (no borrow).
- OVF  output  1  signed two's-complement overflow.
- ZERO  output  1  S == 0.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, OVF=0, ZERO=0.
  - Nibble index=0, carry register=0, operand registers=0.
  - An operation in progress is discarded; nothing is emitted after reset release.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - Register A, B^{W{SUB}}, SUB.
    - carry <= SUB, idx <= 0.
    - Clear S register to 0.
    - Go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Adder inputs each cycle: A nibble idx, B' nibble idx, carry.
    - At each edge: S nibble idx <= adder S; carry <= adder Cout; idx <= idx+1.
    - When idx==NIBBLES-1, the same edge also registers Cout, OVF, ZERO and goes to DONE.
  - DONE: out_valid=1, in_ready=0, outputs stable.
    - On out_valid&&out_ready: go to IDLE; S and flags hold their last value until the next result.
- Latency:
  - Acceptance edge = edge 0; out_valid is high after edge NIBBLES.
  - Minimum initiation interval = NIBBLES+2 cycles (accept, NIBBLES run edges, handshake edge, back in IDLE).
  - There is no acceptance in the DONE→IDLE handshake cycle.
- Flag rules:
  - OVF = (A[W-1] == B'[W-1]) && (S[W-1] != A[W-1]), using the registered inverted B'.
  - ZERO computed on the final W-bit S, including the final nibble.
- Width and wrap:
  - Result is modulo 2^W.
  - idx width is clog2(NIBBLES), minimum 1; idx never exceeds NIBBLES-1.
  - NIBBLES=1 gives RUN of exactly one cycle.
- Simultaneous events:
  - in_valid in RUN/DONE is ignored; the source must hold it until in_ready.
  - out_ready while out_valid=0 has no effect.
  - Input changes after acceptance do not affect the operation in flight.
- Exactly one cl_adder4 instance; no other adder on the datapath.

Test Plan:
- Reset release, A=0x1234, B=0x4321, SUB=0 → out_valid 4 edges after accept; S=0x5555, Cout=0, OVF=0, ZERO=0.
- A=0xFFFF, B=0x0001, SUB=0 → S=0x0000, Cout=1, ZERO=1, OVF=0 (carry ripples through all 4 nibbles).
- A=0x0005, B=0x0007, SUB=1 → S=0xFFFE, Cout=0. Then A=0x8000, B=0x0001, SUB=1 → S=0x7FFF, Cout=1, OVF=1.
- A=0x7FFF, B=0x0001, SUB=0 → S=0x8000, OVF=1, Cout=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 10 cycles → out_valid, S, flags stable throughout, in_ready=0.
  - A new in_valid during RUN/DONE is not accepted.
  - Release out_ready → IDLE next cycle; next operation is accepted.
- Reset and minimum width:
  - Assert rst_n=0 mid-RUN (after 2 nibbles) → all outputs 0 immediately, no out_valid after release; a fresh 0x0001+0x0001 yields 0x0002.
  - Repeat the first scenario with NIBBLES=1 (A=0x9, B=0x8 → S=0x1, Cout=1, OVF=1, latency 1).
